// File: rtl/apb_reg_pkg.sv
// rtl/apb_reg_pkg.sv - FSM state type, wait-counter width and strobe expansion for apb_reg_file
package apb_reg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } fsm_state_e;

   localparam int WAIT_CNT_W = 4;

   // Byte strobes to bit mask; callers truncate to their own data width.
   function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
      logic [63:0] mask;
      mask = '0;
      for (int b = 0; b < 8; b++) begin
         mask[b*8 +: 8] = {8{strb[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// rtl/apb_wait_ctrl.sv - APB transfer FSM with programmable wait-state counter
module apb_wait_ctrl
   import apb_reg_pkg::*;
#(
   parameter int WAIT_STATES = 0
)(
   input  logic clk,
   input  logic rst,
   input  logic sel,
   input  logic enable,
   output logic ready,
   output logic accept,
   output logic commit_en,
   output logic done_entry
);

   localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;
   localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

   fsm_state_e            state, state_nx;
   logic [WAIT_CNT_W-1:0] cnt, cnt_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      accept     = 1'b0;
      commit_en  = 1'b0;
      done_entry = 1'b0;
      case (state)
         IDLE: begin
            if (sel && !enable) begin
               accept = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_nx = WAIT;
                  cnt_nx   = CNT_LOAD;
               end else begin
                  state_nx   = DONE;
                  done_entry = 1'b1;
               end
            end
         end
         WAIT: begin
            // Master dropping PSEL mid-transfer abandons it without side effects.
            if (!sel) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == '0) begin
               state_nx   = DONE;
               done_entry = 1'b1;
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
         end
         DONE: begin
            state_nx  = IDLE;
            commit_en = sel;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign ready = (state != WAIT);

endmodule

// File: rtl/apb_reg_file.sv
// rtl/apb_reg_file.sv - parametrised APB3 register file; define APB_REG_FILE_PSLVERR_EN for PSLVERR
module apb_reg_file
   import apb_reg_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_REGS    = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
)(
   input  logic                           iPCLK,
   input  logic                           iPRESET,
   input  logic                           iPSEL,
   input  logic                           iPENABLE,
   input  logic                           iPWRITE,
   input  logic [DATA_WIDTH/8-1:0]        iPSTRB,
   input  logic [ADDR_WIDTH-1:0]          iPADDR,
   input  logic [DATA_WIDTH-1:0]          iPWDATA,
   output logic [DATA_WIDTH-1:0]          oPRDATA,
   output logic                           oPREADY,
   output logic                           oPSLVERR,
   output logic [NUM_REGS*DATA_WIDTH-1:0] oREG_Q,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] iREG_HW_D,
   output logic [NUM_REGS-1:0]            oREG_WR_PULSE
);

   localparam int BPW     = DATA_WIDTH / 8;
   localparam int ALIGN_W = (BPW > 1) ? $clog2(BPW) : 0;
   localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BPW - 1);
   localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

   logic accept, commit_en, done_entry;

   apb_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_ctrl (
      .clk        (iPCLK),
      .rst        (iPRESET),
      .sel        (iPSEL),
      .enable     (iPENABLE),
      .ready      (oPREADY),
      .accept     (accept),
      .commit_en  (commit_en),
      .done_entry (done_entry)
   );

   logic [ADDR_WIDTH-1:0] offset, word;
   logic                  addr_bad, dec_ro, dec_err;
   logic [IDX_W-1:0]      dec_idx;

   assign offset   = iPADDR - BASE_ADDR;
   assign word     = offset >> ALIGN_W;
   assign addr_bad = (iPADDR < BASE_ADDR) || ((offset & ALIGN_MASK) != '0) || (word >= NUM_REGS_A);
   assign dec_idx  = word[IDX_W-1:0];
   assign dec_ro   = !addr_bad && RO_MASK[dec_idx];
   assign dec_err  = addr_bad || (iPWRITE && dec_ro);

   logic [IDX_W-1:0]      lat_idx;
   logic                  lat_write, lat_err, lat_ro;
   logic [BPW-1:0]        lat_strb;
   logic [DATA_WIDTH-1:0] lat_wdata;

   always_ff @(posedge iPCLK) begin
      if (iPRESET) begin
         lat_idx   <= '0;
         lat_write <= 1'b0;
         lat_err   <= 1'b0;
         lat_ro    <= 1'b0;
         lat_strb  <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         lat_idx   <= dec_idx;
         lat_write <= iPWRITE;
         lat_err   <= dec_err;
         lat_ro    <= dec_ro;
         lat_strb  <= iPSTRB;
         lat_wdata <= iPWDATA;
      end
   end

   // Zero-wait transfers enter DONE on the setup edge, before the latches hold the request.
   logic [IDX_W-1:0] eff_idx;
   logic             eff_write, eff_err, eff_ro;

   assign eff_idx   = accept ? dec_idx  : lat_idx;
   assign eff_write = accept ? iPWRITE  : lat_write;
   assign eff_err   = accept ? dec_err  : lat_err;
   assign eff_ro    = accept ? dec_ro   : lat_ro;

   logic [DATA_WIDTH-1:0]          wr_mask;
   logic                           wr_commit;
   logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat;

   assign wr_mask   = DATA_WIDTH'(strb_to_mask(8'(lat_strb)));
   assign wr_commit = commit_en && lat_write && !lat_err;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (RO_MASK[i]) begin : g_ro
         assign reg_flat[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else begin : g_rw
         logic [DATA_WIDTH-1:0] q;
         always_ff @(posedge iPCLK) begin
            if (iPRESET) begin
               q <= '0;
            end else if (wr_commit && (lat_idx == IDX_W'(i))) begin
               q <= (q & ~wr_mask) | (lat_wdata & wr_mask);
            end
         end
         assign reg_flat[i*DATA_WIDTH +: DATA_WIDTH] = q;
      end
   end

   assign oREG_Q = reg_flat;

   always_ff @(posedge iPCLK) begin
      if (iPRESET) begin
         oREG_WR_PULSE <= '0;
      end else begin
         oREG_WR_PULSE <= '0;
         if (wr_commit) begin
            oREG_WR_PULSE[lat_idx] <= 1'b1;
         end
      end
   end

   logic [DATA_WIDTH-1:0] rd_value;

   always_comb begin
      rd_value = '0;
      if (!eff_err) begin
         rd_value = eff_ro ? iREG_HW_D[eff_idx*DATA_WIDTH +: DATA_WIDTH]
                           : reg_flat[eff_idx*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge iPCLK) begin
      if (iPRESET) begin
         oPRDATA <= '0;
      end else if (done_entry && !eff_write) begin
         oPRDATA <= rd_value;
      end
   end

`ifdef APB_REG_FILE_PSLVERR_EN
   // High exactly while in DONE for a bad address or an RO write.
   logic pslverr_q;
   always_ff @(posedge iPCLK) begin
      if (iPRESET) begin
         pslverr_q <= 1'b0;
      end else begin
         pslverr_q <= done_entry && eff_err;
      end
   end
   assign oPSLVERR = pslverr_q;
`else
   assign oPSLVERR = 1'b0;
`endif

endmodule

// File: doc/apb_reg_file.md
# apb_reg_file

Parametrised APB3 slave register file, the successor to the team's fixed two-register APB test slave. Provides NUM_REGS byte-strobed read/write registers plus per-register read-only status slots, programmable wait-state insertion, per-register write-commit pulses and optional PSLVERR reporting. Sits behind the APB bridge as a generic control/status block feeding datapath modules through a flat register bus.

## Interface
- ADDR_WIDTH, 16: width of iPADDR.
- DATA_WIDTH, 32: register and bus width; multiple of 8, 8..64.
- NUM_REGS, 8: number of registers, 1..64.
- BASE_ADDR, 16'h0000: byte address of register 0; aligned to DATA_WIDTH/8.
- WAIT_STATES, 0: PREADY-low cycles per access, 0..15.
- RO_MASK, 0: NUM_REGS-bit mask; bit i=1 makes register i read-only.
- iPCLK  in  1  APB clock, sole clock.
- iPRESET  in  1  reset; one clock; reset is synchronous and active-high.
- iPSEL, iPENABLE, iPWRITE  in  1 each  APB control.
- iPSTRB  in  DATA_WIDTH/8  byte write strobes.
- iPADDR  in  ADDR_WIDTH  byte address.
- iPWDATA  in  DATA_WIDTH  write data.
- oPRDATA  out  DATA_WIDTH  registered read data.
- oPREADY  out  1  transfer complete.
- oPSLVERR  out  1  error response.
- oREG_Q  out  NUM_REGS*DATA_WIDTH  flat register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH].
- iREG_HW_D  in  NUM_REGS*DATA_WIDTH  status values returned for RO registers (same slicing).
- oREG_WR_PULSE  out  NUM_REGS  one-cycle pulse on committed write to register i.

## Operation
- Index = (iPADDR − BASE_ADDR) / (DATA_WIDTH/8). Address invalid if below BASE_ADDR, index ≥ NUM_REGS, or low log2(DATA_WIDTH/8) bits nonzero.
- FSM states: IDLE, WAIT, DONE. IDLE: on iPSEL & !iPENABLE (setup) latch index, direction, strobes, write data, error flag; go WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES−1), else DONE. WAIT: decrement; at 0 go DONE. DONE: oPREADY=1; commit; return to IDLE (back-to-back setup accepted in the following cycle).
- Write commit: reg ← (reg & ~mask) | (wdata & mask), mask = byte-expanded strobes; oREG_WR_PULSE[i]=1 for one cycle after the commit edge. Strobes all zero: register unchanged, pulse still issued.
- Write to RO register or invalid address: no update, no pulse.
- Read: oPRDATA loaded on the edge entering DONE from register (RW) or iREG_HW_D slice (RO); invalid address loads 0. Held between reads; writes do not change it.
- iPSEL deasserted in WAIT/DONE (protocol violation): abort to IDLE, no commit, no pulse.
- oREG_Q for RO indices is constant 0.

## Timing
- Reset values: oPRDATA 0, oPREADY 1, oPSLVERR 0, oREG_Q 0, oREG_WR_PULSE 0, FSM IDLE, counter 0.
- oPREADY is 1 in IDLE and DONE, 0 in WAIT.
- Access phase length = WAIT_STATES+1 cycles; WAIT_STATES=0 gives zero-wait APB (ready in first access cycle).
- Register value visible on oREG_Q the cycle after DONE; pulse coincides.
- iPRESET asserted mid-transfer: all state to reset values at that edge; pending write discarded.

## Configuration
- APB_REG_FILE_PSLVERR_EN defined: oPSLVERR=1 in DONE for invalid address or write to RO register; 0 otherwise.
- Not defined: oPSLVERR tied 0; such accesses silently ignored (reads return 0).

## Structure
- Package apb_reg_pkg: FSM state enum (IDLE, WAIT, DONE), WAIT counter width constant (4), byte-strobe expansion function.
- Sub-module apb_wait_ctrl: FSM plus wait counter; outputs PREADY, commit enable, read-capture enable. Register array and decode stay in the top.

## Test plan
- Defaults, write 32'hDEADBEEF to 16'h0004 strobe 4'hF then read -> oREG_Q reg1 = DEADBEEF, oREG_WR_PULSE=8'h02 one cycle, oPRDATA=DEADBEEF, oPREADY high in first access cycle.
- Reg0=32'h11223344, write 32'hAABBCCDD strobe 4'b0101 -> reg0=32'h11BB33DD.
- WAIT_STATES=3 -> oPREADY low exactly 3 access cycles, commit on the 4th.
- RO_MASK=8'h04, iREG_HW_D reg2=32'hCAFE0001; write 16'h0008 then read -> no update/pulse, read CAFE0001, oPSLVERR=1 on write only with macro.
- Read 16'h0020 and 16'h0002 -> oPRDATA 0, oPSLVERR 1 with macro, 0 without.
- iPRESET during WAIT of write with WAIT_STATES=3 -> register stays 0, no pulse, oPREADY 1 next cycle.
